// File: rtl/audio_chime_player.sv
// Two-note square-wave chime (NOTE1, gap, NOTE2) streamed one sample per accepted audio-out strobe.
// Optional decaying envelope enabled with macro CHIME_FADE_EN.
module audio_chime_player #(
    parameter logic [31:0] AMPLITUDE    = 32'h0800_0000,
    parameter int          NOTE_SAMPLES = 24000,
    parameter int          GAP_SAMPLES  = 4800,
    parameter int          NOTE1_HALF   = 55,
    parameter int          NOTE2_HALF   = 69
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        play,
    input  logic        stop,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy,
    output logic        done
);

    localparam int MAX_LEN   = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
    localparam int MAX_HALF  = (NOTE1_HALF > NOTE2_HALF) ? NOTE1_HALF : NOTE2_HALF;
    localparam int MAX_COUNT = (MAX_LEN > MAX_HALF) ? MAX_LEN : MAX_HALF;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);
    localparam logic [CNT_W-1:0] H1_LAST   = CNT_W'(NOTE1_HALF - 1);
    localparam logic [CNT_W-1:0] H2_LAST   = CNT_W'(NOTE2_HALF - 1);

    typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sample_q, sample_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   half_last, seg_last;
    logic signed [31:0] amp_level;
`ifdef CHIME_FADE_EN
    logic [31:0]        cnt_x4;
`endif

    // The strobe is combinational so the controller sees exactly one write per allowed cycle.
    assign write_audio_out         = audio_out_allowed && (state_q != IDLE);
    assign left_channel_audio_out  = data_q;
    assign right_channel_audio_out = data_q;
    assign busy                    = (state_q != IDLE);
    assign done                    = done_q;

    // NOTE: every signal driven here gets a default first, otherwise unassigned paths infer latches.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        phase_d   = phase_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        half_last = (state_q == NOTE1) ? H1_LAST : H2_LAST;
        seg_last  = (state_q == GAP) ? GAP_LAST : NOTE_LAST;

        case (state_q)
            IDLE: begin
                if (play && !stop) begin
                    state_d  = NOTE1;
                    sample_d = '0;
                    phase_d  = '0;
                    neg_d    = 1'b0;
                end
            end
            default: begin
                if (stop) begin
                    state_d  = IDLE;
                    sample_d = '0;
                    phase_d  = '0;
                    neg_d    = 1'b0;
                end else if (write_audio_out) begin
                    if (sample_q == seg_last) begin
                        sample_d = '0;
                        phase_d  = '0;
                        neg_d    = 1'b0;
                        if (state_q == NOTE1) begin
                            state_d = GAP;
                        end else if (state_q == GAP) begin
                            state_d = NOTE2;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                        if (state_q != GAP) begin
                            if (phase_q == half_last) begin
                                phase_d = '0;
                                neg_d   = ~neg_q;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // Output data is computed from the post-write state so the next strobe carries it.
    always_comb begin
        amp_level = $signed(AMPLITUDE);
`ifdef CHIME_FADE_EN
        cnt_x4 = 32'(sample_d) << 2;
        if (cnt_x4 >= 32'(3 * NOTE_SAMPLES)) begin
            amp_level = $signed(AMPLITUDE) >>> 3;
        end else if (cnt_x4 >= 32'(2 * NOTE_SAMPLES)) begin
            amp_level = $signed(AMPLITUDE) >>> 2;
        end else if (cnt_x4 >= 32'(NOTE_SAMPLES)) begin
            amp_level = $signed(AMPLITUDE) >>> 1;
        end
`endif
        if (state_d == NOTE1 || state_d == NOTE2) begin
            data_d = neg_d ? -amp_level : amp_level;
        end else begin
            data_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            phase_q  <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            phase_q  <= phase_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_audio_chime_player.sv
// Scoreboard bench for audio_chime_player: stimulus queues expected samples from an
// arithmetic chime model, a monitor pops and compares on every write strobe.
module tb_audio_chime_player;

    localparam int          NS        = 8;
    localparam int          GS        = 2;
    localparam int          H1        = 2;
    localparam int          H2        = 3;
    localparam logic [31:0] AMP       = 32'h0000_1000;
    localparam int          CHIME_LEN = 2 * NS + GS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] left_out, right_out;
    logic        busy, done;

    always #10 clk = ~clk;

    audio_chime_player #(
        .AMPLITUDE   (AMP),
        .NOTE_SAMPLES(NS),
        .GAP_SAMPLES (GS),
        .NOTE1_HALF  (H1),
        .NOTE2_HALF  (H2)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .play                   (play),
        .stop                   (stop),
        .audio_out_allowed      (allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .busy                   (busy),
        .done                   (done)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          strobe_count = 0;
    int          done_count = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: square wave toggling every `half` samples, optional quarter-note decay.
    function automatic logic [31:0] note_sample(input int half, input int i);
        logic [31:0] mag;
        mag = AMP;
`ifdef CHIME_FADE_EN
        mag = AMP >> ((i * 4) / NS);
`endif
        if (((i / half) % 2) == 1) return -mag;
        return mag;
    endfunction

    task automatic push_chime(input int count);
        logic [31:0] seq[$];
        for (int i = 0; i < NS; i++) seq.push_back(note_sample(H1, i));
        for (int i = 0; i < GS; i++) seq.push_back(32'h0);
        for (int i = 0; i < NS; i++) seq.push_back(note_sample(H2, i));
        for (int i = 0; i < count; i++) exp_q.push_back(seq[i]);
    endtask

    // Monitor: every strobe consumes one expected sample.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (write_audio_out === 1'b1) begin
                strobe_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", left_out, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("left_sample", left_out, e);
                    check("right_sample", right_out, e);
                end
            end
            if (done === 1'b1) begin
                done_count++;
                check("busy_low_with_done", busy, 0);
            end
        end
    end

    // mode 0: allowed held high, 1: allowed toggles starting low, 2: random allowed + stray play pulses
    task automatic run_play(input int mode, input string tag);
        int cycles, d0, s0;
        bit ended;
        push_chime(CHIME_LEN);
        d0 = done_count;
        s0 = strobe_count;
        @(posedge clk); #2;
        play = 1'b1;
        allowed = (mode == 0);
        @(posedge clk); #2;
        play = 1'b0;
        cycles = 0;
        ended = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            case (mode)
                0: allowed = 1'b1;
                1: allowed = (c % 2 == 0);
                default: begin
                    allowed = 1'($urandom_range(0, 1));
                    play = (strobe_count - s0 < CHIME_LEN) && ($urandom_range(0, 3) == 0);
                end
            endcase
            @(negedge clk);
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            cycles = c;
            @(posedge clk); #2;
        end
        play = 1'b0;
        allowed = 1'b1;
        check({tag, "_ended"}, ended, 1);
        if (mode != 2) check({tag, "_busy_cycles"}, cycles, (mode == 1) ? 2 * CHIME_LEN : CHIME_LEN);
        @(posedge clk); #2;
        check({tag, "_done_pulses"}, done_count - d0, 1);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_strobes(input int target);
        for (int k = 0; k < 200 && strobe_count < target; k++) @(posedge clk);
    endtask

    initial begin
        int s, d0;
        allowed = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_write", write_audio_out, 0);
        check("reset_left", left_out, 0);
        check("reset_right", right_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(posedge clk); #2;
        reset = 1'b0;

        run_play(0, "steady");
        run_play(1, "toggle");

        // Abort with stop after the fifth strobe.
        push_chime(5);
        s = strobe_count;
        d0 = done_count;
        @(posedge clk); #2;
        play = 1'b1;
        @(posedge clk); #2;
        play = 1'b0;
        wait_strobes(s + 5);
        #2;
        stop = 1'b1;
        allowed = 1'b0;
        check("stop_after_five", strobe_count - s, 5);
        @(posedge clk); #2;
        stop = 1'b0;
        allowed = 1'b1;
        @(negedge clk);
        check("stop_busy", busy, 0);
        check("stop_write", write_audio_out, 0);
        check("stop_left", left_out, 0);
        check("stop_done_none", done_count - d0, 0);
        check("stop_queue_empty", exp_q.size(), 0);
        run_play(0, "restart");

        // play and stop together in IDLE.
        s = strobe_count;
        @(posedge clk); #2;
        play = 1'b1;
        stop = 1'b1;
        @(posedge clk); #2;
        play = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("play_stop_busy", busy, 0);
        repeat (4) @(posedge clk);
        check("play_stop_no_strobe", strobe_count - s, 0);

        run_play(2, "random_a");
        run_play(2, "random_b");

        // Reset while in GAP: strobe 10 is the second gap sample, reset lands in that cycle.
        push_chime(NS + 2);
        s = strobe_count;
        d0 = done_count;
        @(posedge clk); #2;
        play = 1'b1;
        @(posedge clk); #2;
        play = 1'b0;
        wait_strobes(s + NS + 1);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("gap_strobe_before_reset", write_audio_out, 1);
        @(negedge clk);
        check("gap_reset_write", write_audio_out, 0);
        check("gap_reset_left", left_out, 0);
        check("gap_reset_right", right_out, 0);
        check("gap_reset_busy", busy, 0);
        check("gap_reset_done", done, 0);
        check("gap_reset_queue", exp_q.size(), 0);
        push_chime(CHIME_LEN);
        @(posedge clk); #2;
        reset = 1'b0;
        play = 1'b1;
        @(posedge clk); #2;
        play = 1'b0;
        @(negedge clk);
        check("play_after_reset_busy", busy, 1);
        for (int k = 0; k < 100 && (busy || exp_q.size() != 0); k++) @(negedge clk);
        @(posedge clk); #2;
        check("post_reset_queue_empty", exp_q.size(), 0);
        check("post_reset_done_once", done_count - d0, 1);

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
